// File: rtl/ts_audio_pkg.sv
// ts_audio_pkg: shared constants, types and the per-channel mix helper for
// the Turbosound-FM output mixer (ts_audio_mix).
//
// Contents:
//   MIX_W            width of one mixed / averaged sample
//   BEEP_W, TAPE_W   fixed weights of the 1-bit beeper and tape-in sources
//   COVOX_SH, TS_SH  left shifts applied to the Covox and Turbosound sources
//   sample_t         16-bit signed sample
//   ts_state_e       output FSM state encoding
//   mix_calc()       one channel's weighted sum of all sources
package ts_audio_pkg;

  localparam int MIX_W    = 16;
  localparam int BEEP_W   = 4096;
  localparam int TAPE_W   = 1024;
  localparam int COVOX_SH = 4;
  localparam int TS_SH    = 3;

  typedef logic signed [MIX_W-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILT = 2'd1,
    ST_EMIT = 2'd2
  } ts_state_e;

  // Worst case is 2047*8 + 4096 + 1024 + 255*16 = 25576, and the minimum is
  // -2048*8 = -16384, so 16 signed bits always hold the sum exactly.
  function automatic sample_t mix_calc(input logic signed [11:0] ts,
                                       input logic              beep,
                                       input logic              tape,
                                       input logic [7:0]        covox);
    sample_t m;
    m = sample_t'(ts) <<< TS_SH;
    if (beep) m = m + sample_t'(BEEP_W);
    if (tape) m = m + sample_t'(TAPE_W);
    m = m + (sample_t'({8'd0, covox}) << COVOX_SH);
    return m;
  endfunction

endpackage

// File: rtl/ts_audio_mix_if.sv
// ts_audio_mix_if: signal bundle between the sound sources / audio front end
// and the ts_audio_mix block.
//
// Signals:
//   CE                 sample tick (one CLK wide, spaced >= 3 CLK apart)
//   TS_L, TS_R         12-bit signed Turbosound streams
//   BEEPER, TAPE_IN    1-bit sources
//   COVOX              8-bit unsigned Covox DAC value
//   MUTE               zeroes emitted samples
//   OUT_L, OUT_R       16-bit signed output samples
//   OUT_VALID          one-CLK strobe marking a new OUT_L/OUT_R pair
//   DBG_STATE          current output FSM state, for observation only
//
// Handshake: there is no backpressure. OUT_VALID is a single-cycle strobe and
// the consumer must take OUT_L/OUT_R in that cycle; CE is likewise an
// unconditional tick that the mixer always accepts.
//
// Modports: master = source / front-end side, slave = the mixer.
interface ts_audio_mix_if;
  import ts_audio_pkg::*;

  logic              CE;
  logic signed [11:0] TS_L;
  logic signed [11:0] TS_R;
  logic              BEEPER;
  logic              TAPE_IN;
  logic [7:0]        COVOX;
  logic              MUTE;
  sample_t           OUT_L;
  sample_t           OUT_R;
  logic              OUT_VALID;
  ts_state_e         DBG_STATE;

  modport master (
    output CE, TS_L, TS_R, BEEPER, TAPE_IN, COVOX, MUTE,
    input  OUT_L, OUT_R, OUT_VALID, DBG_STATE
  );

  modport slave (
    input  CE, TS_L, TS_R, BEEPER, TAPE_IN, COVOX, MUTE,
    output OUT_L, OUT_R, OUT_VALID, DBG_STATE
  );

endinterface

// File: rtl/ts_dc_block.sv
// ts_dc_block: one channel of the DC-blocking high-pass used by ts_audio_mix
// when the TS_DCBLOCK_EN macro is defined. Without the macro this file
// contributes no module.
//
//   y = x - x_prev + y_prev - (y_prev >>> 8), computed in 18 bits, then
//   saturated to the 16-bit sample range.
//
// Ports:
//   CLK, RESET_s   clock, asynchronous active-high reset (state -> 0)
//   en_i           advance the filter one step (x_prev/y_prev/y_o update)
//   x_i            input sample
//   y_o            registered, saturated output sample
`ifdef TS_DCBLOCK_EN
module ts_dc_block
  import ts_audio_pkg::*;
(
  input  logic    CLK,
  input  logic    RESET_s,
  input  logic    en_i,
  input  sample_t x_i,
  output sample_t y_o
);

  localparam int FW = 18;
  typedef logic signed [FW-1:0] filt_t;

  sample_t x_prev_q;
  filt_t   y_prev_q;
  sample_t y_q;
  filt_t   y_calc;
  sample_t y_sat;

  always_comb begin
    y_calc = filt_t'(x_i) - filt_t'(x_prev_q) + y_prev_q - (y_prev_q >>> 8);
    y_sat  = sample_t'(y_calc);
    if (y_calc > filt_t'(32767)) begin
      y_sat = sample_t'(16'h7FFF);
    end else if (y_calc < filt_t'(-32768)) begin
      y_sat = sample_t'(16'h8000);
    end
  end

  // y_prev keeps the unsaturated 18-bit value so the recursion is not
  // disturbed by output clipping.
  always_ff @(posedge CLK or posedge RESET_s) begin
    if (RESET_s) begin
      x_prev_q <= '0;
      y_prev_q <= '0;
      y_q      <= '0;
    end else if (en_i) begin
      x_prev_q <= x_i;
      y_prev_q <= y_calc;
      y_q      <= y_sat;
    end
  end

  assign y_o = y_q;

endmodule
`endif

// File: rtl/ts_audio_mix.sv
// ts_audio_mix: Turbosound-FM output mixer and decimator.
//
// On every CE the Turbosound, beeper, tape-in and Covox sources are mixed per
// channel with fixed weights and summed into a per-channel accumulator. Every
// DECIM ticks the block average (floor) is latched and handed to a small
// output FSM which emits it on OUT_L/OUT_R with a one-cycle OUT_VALID.
//
// Optional feature: macro TS_DCBLOCK_EN inserts a FILT state running a
// per-channel DC-blocking high-pass (ts_dc_block) before emission, adding one
// CLK of latency.
//
// Parameters:
//   DECIM      CE ticks averaged per output sample, power of two, 2..256
// Ports:
//   CLK        system clock
//   RESET_s    asynchronous active-high reset
//   bus        ts_audio_mix_if.slave (sources in, samples / strobe out)
module ts_audio_mix
  import ts_audio_pkg::*;
#(
  parameter int DECIM = 64
) (
  input logic           CLK,
  input logic           RESET_s,
  ts_audio_mix_if.slave bus
);

  localparam int SH    = $clog2(DECIM);
  localparam int ACC_W = MIX_W + SH;
  typedef logic signed [ACC_W-1:0] acc_t;

  logic [SH-1:0] count_q, count_d;
  acc_t          acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  acc_t          sum_l, sum_r, shf_l, shf_r;
  sample_t       mix_l, mix_r;
  sample_t       avg_l_q, avg_l_d, avg_r_q, avg_r_d;
  logic          boundary;

  ts_state_e     state_q, state_d;
  sample_t       src_l, src_r;
  sample_t       emit_l, emit_r;
  sample_t       out_l_q, out_r_q;

  assign mix_l    = mix_calc(bus.TS_L, bus.BEEPER, bus.TAPE_IN, bus.COVOX);
  assign mix_r    = mix_calc(bus.TS_R, bus.BEEPER, bus.TAPE_IN, bus.COVOX);
  assign boundary = bus.CE && (count_q == SH'(DECIM - 1));

  // The boundary tick's own mix is part of the block, so the average is
  // taken from acc + mix rather than from the stored accumulator alone.
  assign sum_l = acc_l_q + acc_t'(mix_l);
  assign sum_r = acc_r_q + acc_t'(mix_r);
  assign shf_l = sum_l >>> SH;
  assign shf_r = sum_r >>> SH;

  // Accumulation is independent of the output FSM.
  always_comb begin
    count_d = count_q;
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    avg_l_d = avg_l_q;
    avg_r_d = avg_r_q;
    if (bus.CE) begin
      if (boundary) begin
        count_d = '0;
        acc_l_d = '0;
        acc_r_d = '0;
        avg_l_d = sample_t'(shf_l);
        avg_r_d = sample_t'(shf_r);
      end else begin
        count_d = count_q + SH'(1);
        acc_l_d = sum_l;
        acc_r_d = sum_r;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET_s) begin
    if (RESET_s) begin
      count_q <= '0;
      acc_l_q <= '0;
      acc_r_q <= '0;
      avg_l_q <= '0;
      avg_r_q <= '0;
    end else begin
      count_q <= count_d;
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
      avg_l_q <= avg_l_d;
      avg_r_q <= avg_r_d;
    end
  end

  // Output FSM. CE spacing of >= 3 CLK guarantees the FSM is back in IDLE
  // before the next boundary can occur.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (boundary) begin
`ifdef TS_DCBLOCK_EN
          state_d = ST_FILT;
`else
          state_d = ST_EMIT;
`endif
        end
      end
      ST_FILT: state_d = ST_EMIT;
      ST_EMIT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET_s) begin
    if (RESET_s) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef TS_DCBLOCK_EN
  logic filt_en;
  assign filt_en = (state_q == ST_FILT);

  ts_dc_block u_dc_l (
    .CLK     (CLK),
    .RESET_s (RESET_s),
    .en_i    (filt_en),
    .x_i     (avg_l_q),
    .y_o     (src_l)
  );

  ts_dc_block u_dc_r (
    .CLK     (CLK),
    .RESET_s (RESET_s),
    .en_i    (filt_en),
    .x_i     (avg_r_q),
    .y_o     (src_r)
  );
`else
  assign src_l = avg_l_q;
  assign src_r = avg_r_q;
`endif

  // MUTE only gates what is emitted; the sample path keeps running.
  assign emit_l = bus.MUTE ? '0 : src_l;
  assign emit_r = bus.MUTE ? '0 : src_r;

  always_ff @(posedge CLK or posedge RESET_s) begin
    if (RESET_s) begin
      out_l_q <= '0;
      out_r_q <= '0;
    end else if (state_q == ST_EMIT) begin
      out_l_q <= emit_l;
      out_r_q <= emit_r;
    end
  end

  // The new pair is visible during the EMIT cycle itself and is then held.
  assign bus.OUT_L     = (state_q == ST_EMIT) ? emit_l : out_l_q;
  assign bus.OUT_R     = (state_q == ST_EMIT) ? emit_r : out_r_q;
  assign bus.OUT_VALID = (state_q == ST_EMIT);
  assign bus.DBG_STATE = state_q;

endmodule

// File: tb/tb_ts_audio_mix.sv
// tb_ts_audio_mix: self-checking bench for ts_audio_mix (DECIM = 4).
// Stimulus tasks drive CE ticks; a reference model computes each block's
// expected output pair and its arrival cycle into queues; a monitor on the
// falling edge pops and compares whenever OUT_VALID is seen, and checks that
// outputs hold between strobes and are zero under reset.
module tb_ts_audio_mix;
  import ts_audio_pkg::*;

  localparam int DECIM = 4;
`ifdef TS_DCBLOCK_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESET_s = 1'b1;
  int   cyc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  ts_audio_mix_if bus ();

  ts_audio_mix #(.DECIM(DECIM)) dut (
    .CLK     (CLK),
    .RESET_s (RESET_s),
    .bus     (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          last_l   = 0;
  int          last_r   = 0;

  // Reference model state
  int blk_l[$];
  int blk_r[$];
  int xp_l = 0, yp_l = 0, xp_r = 0, yp_r = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int floor_div(input int a, input int d);
    int q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int mix_ref(input int ts, input bit bp, input bit tp, input int cv);
    return ts * 8 + (bp ? 4096 : 0) + (tp ? 1024 : 0) + cv * 16;
  endfunction

  // Reduce to the 18-bit two's-complement range the filter works in.
  function automatic int wrap18(input int v);
    int m;
    m = v % 262144;
    if (m < 0) m = m + 262144;
    if (m >= 131072) m = m - 262144;
    return m;
  endfunction

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int sum_q(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  // Model one CE: collect the block, and on the DECIM-th tick push the
  // expected pair with the cycle at which the monitor should see it.
  task automatic model_ce(input int l, input int r, input bit bp, input bit tp,
                          input int cv, input bit mute);
    int al, ar, yl, yr;
    logic [15:0] pl, pr;
    blk_l.push_back(mix_ref(l, bp, tp, cv));
    blk_r.push_back(mix_ref(r, bp, tp, cv));
    if (blk_l.size() == DECIM) begin
      al = floor_div(sum_q(blk_l), DECIM);
      ar = floor_div(sum_q(blk_r), DECIM);
      blk_l.delete();
      blk_r.delete();
`ifdef TS_DCBLOCK_EN
      yl = wrap18(al - xp_l + yp_l - floor_div(yp_l, 256));
      yr = wrap18(ar - xp_r + yp_r - floor_div(yp_r, 256));
      xp_l = al; yp_l = yl;
      xp_r = ar; yp_r = yr;
      yl = sat16(yl);
      yr = sat16(yr);
`else
      yl = al;
      yr = ar;
`endif
      if (mute) begin
        yl = 0;
        yr = 0;
      end
      pl = 16'(yl);
      pr = 16'(yr);
      exp_q.push_back({pl, pr});
      exp_cyc_q.push_back(cyc + LAT);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic ce_tick(input int l, input int r, input bit bp, input bit tp,
                         input int cv, input bit mute, input int gap);
    @(posedge CLK);
    #1;
    bus.CE      = 1'b1;
    bus.TS_L    = 12'(l);
    bus.TS_R    = 12'(r);
    bus.BEEPER  = bp;
    bus.TAPE_IN = tp;
    bus.COVOX   = 8'(cv);
    bus.MUTE    = mute;
    model_ce(l, r, bp, tp, cv, mute);
    @(posedge CLK);
    #1;
    bus.CE = 1'b0;
    repeat (gap) @(posedge CLK);
  endtask

  task automatic pulse_reset();
    @(posedge CLK);
    #1;
    RESET_s = 1'b1;
    blk_l.delete();
    blk_r.delete();
    xp_l = 0; yp_l = 0; xp_r = 0; yp_r = 0;
    @(posedge CLK);
    #1;
    RESET_s = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    logic [31:0] e;
    int          ec;
    if (RESET_s) begin
      check("reset_out_l", int'(bus.OUT_L), 0);
      check("reset_out_r", int'(bus.OUT_R), 0);
      check("reset_valid", int'(bus.OUT_VALID), 0);
      last_l = 0;
      last_r = 0;
    end else if (bus.OUT_VALID) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        last_l = int'($signed(e[31:16]));
        last_r = int'($signed(e[15:0]));
        check("out_l", int'(bus.OUT_L), last_l);
        check("out_r", int'(bus.OUT_R), last_r);
        check("valid_cycle", cyc, ec);
      end
    end else begin
      check("hold_l", int'(bus.OUT_L), last_l);
      check("hold_r", int'(bus.OUT_R), last_r);
      if (exp_cyc_q.size() != 0 && cyc > exp_cyc_q[0])
        check("missed_valid", cyc, exp_cyc_q[0]);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int g;
    bus.CE = 1'b0; bus.TS_L = '0; bus.TS_R = '0; bus.BEEPER = 1'b0;
    bus.TAPE_IN = 1'b0; bus.COVOX = '0; bus.MUTE = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RESET_s = 1'b0;

    // Basic average: 100*8 = 800 on left, right zero
    for (int i = 0; i < 4; i++) ce_tick(100, 0, 0, 0, 0, 0, 2);
    // Beeper + full Covox: 4096 + 4080 = 8176 both channels, two blocks
    for (int i = 0; i < 8; i++) ce_tick(0, 0, 1, 0, 255, 0, 2);
    // Alternating +/-1000 cancels; constant -1 floors to -8
    for (int i = 0; i < 4; i++) ce_tick((i % 2 == 0) ? 1000 : -1000, 0, 0, 0, 0, 0, 3);
    for (int i = 0; i < 4; i++) ce_tick(-1, -1, 0, 0, 0, 0, 2);
    // Tape-in weight
    for (int i = 0; i < 4; i++) ce_tick(0, 5, 0, 1, 0, 0, 2);
    // Reset mid-block discards the partial sum
    for (int i = 0; i < 2; i++) ce_tick(100, 0, 0, 0, 0, 0, 2);
    pulse_reset();
    for (int i = 0; i < 4; i++) ce_tick(0, 0, 0, 0, 0, 0, 2);
    // Step input: steady 800 (decaying with the DC blocker)
    for (int i = 0; i < 12; i++) ce_tick(100, 0, 0, 0, 0, 0, 1);
    // Muted blocks keep strobing with zero, then release
    for (int i = 0; i < 8; i++) ce_tick(100, 0, 0, 0, 0, 1, 2);
    for (int i = 0; i < 4; i++) ce_tick(100, 0, 0, 0, 0, 0, 2);
    // Extremes of the mix range
    for (int i = 0; i < 4; i++) ce_tick(2047, -2048, 1, 1, 255, 0, 2);
    for (int i = 0; i < 4; i++) ce_tick(-2048, 2047, 0, 0, 0, 0, 2);
    // Randomized blocks
    for (int b = 0; b < 30; b++) begin
      bit m;
      m = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < DECIM; i++) begin
        g = $urandom_range(1, 4);
        ce_tick(int'($urandom_range(0, 4095)) - 2048,
                int'($urandom_range(0, 4095)) - 2048,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 255)), m, g);
      end
    end

    // Drain: bounded wait for outstanding samples
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge CLK);
    repeat (3) @(posedge CLK);
    check("drain_pending", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
